// File: rtl/spi_xfer_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// spi_ctrl_pkg
//   Shared definitions for the SPI burst sequencer:
//     - state_t   : FSM state encoding (3-bit)
//     - DEF_*     : default timing/width constants
//     - max2()    : helper for counter width sizing
//     - ld_val()  : reload value for a "count N cycles" down-counter (N-1, floor 0)
// -----------------------------------------------------------------------------
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_FETCH = 3'd2,
        ST_SHIFT = 3'd3,
        ST_GAP   = 3'd4,
        ST_HOLD  = 3'd5
    } state_t;

    localparam int unsigned DEF_WIDTH    = 8;
    localparam int unsigned DEF_LEN_W    = 4;
    localparam int unsigned DEF_CS_SETUP = 2;
    localparam int unsigned DEF_CS_HOLD  = 2;
    localparam int unsigned DEF_GAP      = 1;
    localparam int unsigned DEF_TIMEOUT  = 64;

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // A down-counter loaded with N-1 reaches zero on the Nth cycle.
    function automatic int unsigned ld_val(input int unsigned n);
        return (n > 0) ? n - 1 : 0;
    endfunction

endpackage

// File: rtl/spi_xfer_sequencer_delay_cnt.sv
// -----------------------------------------------------------------------------
// spi_delay_cnt
//   Loadable saturating down-counter. o_done is high while the count is zero.
//   Ports:
//     i_clk       clock
//     i_rst       asynchronous active-high reset
//     i_load      load i_load_val this cycle (takes priority over decrement)
//     i_load_val  reload value
//     o_done      count == 0
// -----------------------------------------------------------------------------
module spi_delay_cnt #(
    parameter int unsigned CNT_W = 7
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/spi_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// spi_xfer_sequencer
//   Sequences multi-byte SPI bursts through spi_top for the SPI-to-I2C bridge.
//   Frames each burst with the slave enable, honouring CS setup/hold and the
//   inter-byte gap, streams TX bytes in and captured RX bytes out, and aborts
//   a byte that never completes.
//   Ports:
//     clk_i, reset_i              clock, async active-high reset
//     cmd_valid_i/cmd_ready_o     burst command handshake (ready only in IDLE)
//     cmd_len_i                   burst length minus one
//     tx_data_i/tx_valid_i/
//       tx_ready_o                TX byte stream (ready only in FETCH)
//     rx_data_o/rx_valid_o        captured byte, one-cycle valid pulse
//     spi_enable_o                slave enable to spi_top
//     spi_tx_data_o               byte presented to spi_top
//     spi_rx_data_i/spi_done_i    byte result / completion pulse from spi_top
//     busy_o                      not IDLE
//     timeout_o                   sticky abort flag, cleared on next command
// -----------------------------------------------------------------------------
module spi_xfer_sequencer
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned LEN_W    = DEF_LEN_W,
    parameter int unsigned CS_SETUP = DEF_CS_SETUP,
    parameter int unsigned CS_HOLD  = DEF_CS_HOLD,
    parameter int unsigned GAP      = DEF_GAP,
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [LEN_W-1:0] cmd_len_i,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             spi_enable_o,
    output logic [WIDTH-1:0] spi_tx_data_o,
    input  logic [WIDTH-1:0] spi_rx_data_i,
    input  logic             spi_done_i,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam int unsigned CNT_MAX = max2(max2(CS_SETUP, CS_HOLD), max2(GAP, TIMEOUT));
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(ld_val(CS_SETUP));
    localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(ld_val(CS_HOLD));
    localparam logic [CNT_W-1:0] GAP_LD     = CNT_W'(ld_val(GAP));
    localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(ld_val(TIMEOUT));

    state_t             r_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [WIDTH-1:0]   r_rx_data;
    logic               r_rx_valid;
    logic               r_enable;
    logic [WIDTH-1:0]   r_tx_data;
    logic               r_timeout;

    logic               w_cnt_load;
    logic [CNT_W-1:0]   w_cnt_val;
    logic               w_cnt_done;

    // One counter serves SETUP, GAP, HOLD and the SHIFT timeout. It is
    // reloaded on the edge that enters each timed state, so the state then
    // lasts exactly (load value + 1) cycles.
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = SETUP_LD;
                end
            end
            ST_FETCH: begin
                if (tx_valid_i) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = TIMEOUT_LD;
                end
            end
            ST_SHIFT: begin
                if (spi_done_i) begin
                    if (r_remaining == '0) begin
                        w_cnt_load = 1'b1;
                        w_cnt_val  = HOLD_LD;
                    end else if (GAP > 0) begin
                        w_cnt_load = 1'b1;
                        w_cnt_val  = GAP_LD;
                    end
                end else if (w_cnt_done) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = HOLD_LD;
                end
            end
            default: begin
                w_cnt_load = 1'b0;
                w_cnt_val  = '0;
            end
        endcase
    end

    spi_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay_cnt (
        .i_clk      (clk_i),
        .i_rst      (reset_i),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .o_done     (w_cnt_done)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_remaining <= '0;
            r_rx_data   <= '0;
            r_rx_valid  <= 1'b0;
            r_enable    <= 1'b0;
            r_tx_data   <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid_i) begin
                        r_remaining <= cmd_len_i;
                        r_timeout   <= 1'b0;
                        r_enable    <= 1'b1;
                        r_state     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_cnt_done) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    // Underrun stalls here with enable held; no timeout.
                    if (tx_valid_i) begin
                        r_tx_data <= tx_data_i;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // A done arriving on the final timeout cycle still counts.
                    if (spi_done_i) begin
                        r_rx_data  <= spi_rx_data_i;
                        r_rx_valid <= 1'b1;
                        if (r_remaining == '0) begin
                            r_state <= ST_HOLD;
                        end else begin
                            r_remaining <= r_remaining - LEN_W'(1);
                            r_state     <= (GAP > 0) ? ST_GAP : ST_FETCH;
                        end
                    end else if (w_cnt_done) begin
                        r_timeout   <= 1'b1;
                        r_remaining <= '0;
                        r_state     <= ST_HOLD;
                    end
                end
                ST_GAP: begin
                    if (w_cnt_done) begin
                        r_state <= ST_FETCH;
                    end
                end
                ST_HOLD: begin
                    if (w_cnt_done) begin
                        r_enable <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_enable <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = (r_state == ST_IDLE);
    assign tx_ready_o    = (r_state == ST_FETCH);
    assign busy_o        = (r_state != ST_IDLE);
    assign rx_data_o     = r_rx_data;
    assign rx_valid_o    = r_rx_valid;
    assign spi_enable_o  = r_enable;
    assign spi_tx_data_o = r_tx_data;
    assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_spi_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_xfer_sequencer
//   Directed bench for spi_xfer_sequencer with default timing
//   (CS_SETUP=2, CS_HOLD=2, GAP=1, TIMEOUT=64). Inputs are driven and
//   outputs sampled 1 time unit after each rising edge; a negedge monitor
//   tallies enable-high cycles and rx_valid pulses.
// -----------------------------------------------------------------------------
module tb_spi_xfer_sequencer;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LEN_W = 4;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic [WIDTH-1:0] tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             spi_enable;
    logic [WIDTH-1:0] spi_tx_data;
    logic [WIDTH-1:0] spi_rx_data;
    logic             spi_done;
    logic             busy;
    logic             timeout;

    int               n_checks = 0;
    int               n_errors = 0;
    int               en_cycles = 0;
    int               rx_pulses = 0;
    logic [WIDTH-1:0] rx_last = '0;

    always #5 clk = ~clk;

    spi_xfer_sequencer #(
        .WIDTH    (WIDTH),
        .LEN_W    (LEN_W),
        .CS_SETUP (2),
        .CS_HOLD  (2),
        .GAP      (1),
        .TIMEOUT  (64)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_i),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_len_i     (cmd_len),
        .tx_data_i     (tx_data),
        .tx_valid_i    (tx_valid),
        .tx_ready_o    (tx_ready),
        .rx_data_o     (rx_data),
        .rx_valid_o    (rx_valid),
        .spi_enable_o  (spi_enable),
        .spi_tx_data_o (spi_tx_data),
        .spi_rx_data_i (spi_rx_data),
        .spi_done_i    (spi_done),
        .busy_o        (busy),
        .timeout_o     (timeout)
    );

    always @(negedge clk) begin
        if (spi_enable) en_cycles <= en_cycles + 1;
        if (rx_valid) begin
            rx_pulses <= rx_pulses + 1;
            rx_last   <= rx_data;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tx_ready(input string tag);
        int n = 0;
        while (!tx_ready && n < 100) begin
            tick();
            n++;
        end
        check_val({tag, "_tx_ready_wait"}, 32'(tx_ready), 32'd1);
    endtask

    task automatic start_cmd(input logic [LEN_W-1:0] len, input string tag);
        cmd_len   = len;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check_val({tag, "_enable_on"}, 32'(spi_enable), 32'd1);
    endtask

    // Feed one byte and complete it with spi_done after d cycles in SHIFT.
    task automatic send_byte(input logic [WIDTH-1:0] tx, input logic [WIDTH-1:0] rx,
                             input int d, input string tag);
        tx_data  = tx;
        tx_valid = 1'b1;
        wait_tx_ready(tag);
        tick();
        tx_valid = 1'b0;
        check_val({tag, "_spi_tx"}, 32'(spi_tx_data), 32'(tx));
        check_val({tag, "_txrdy_shift"}, 32'(tx_ready), 32'd0);
        repeat (d - 1) tick();
        spi_rx_data = rx;
        spi_done    = 1'b1;
        tick();
        spi_done = 1'b0;
        check_val({tag, "_rx_valid"}, 32'(rx_valid), 32'd1);
        check_val({tag, "_rx_data"}, 32'(rx_data), 32'(rx));
    endtask

    initial begin
        int e0;
        int r0;
        int n;

        reset_i     = 1'b1;
        cmd_valid   = 1'b0;
        cmd_len     = '0;
        tx_data     = '0;
        tx_valid    = 1'b0;
        spi_rx_data = '0;
        spi_done    = 1'b0;
        repeat (2) tick();

        // Reset state
        check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_enable", 32'(spi_enable), 32'd0);
        check_val("rst_tx_ready", 32'(tx_ready), 32'd0);
        check_val("rst_rx_valid", 32'(rx_valid), 32'd0);
        check_val("rst_timeout", 32'(timeout), 32'd0);
        check_val("rst_rx_data", 32'(rx_data), 32'd0);
        check_val("rst_spi_tx", 32'(spi_tx_data), 32'd0);
        reset_i = 1'b0;
        tick();

        // 1-byte burst: enable high 2 + 1 + 8 + 2 = 13 cycles
        e0 = en_cycles;
        r0 = rx_pulses;
        start_cmd(4'd0, "b1");
        send_byte(8'hA5, 8'h3C, 8, "b1");
        tick();
        check_val("b1_rx_pulse_end", 32'(rx_valid), 32'd0);
        check_val("b1_hold_enable", 32'(spi_enable), 32'd1);
        tick();
        check_val("b1_enable_off", 32'(spi_enable), 32'd0);
        check_val("b1_busy_off", 32'(busy), 32'd0);
        check_val("b1_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        check_val("b1_en_cycles", 32'(en_cycles - e0), 32'd13);
        check_val("b1_rx_count", 32'(rx_pulses - r0), 32'd1);
        check_val("b1_rx_last", 32'(rx_last), 32'h3C);
        check_val("b1_timeout", 32'(timeout), 32'd0);

        // 4-byte burst: enable high 2 + 4*(1+3) + 3*1 + 2 = 23 cycles
        e0 = en_cycles;
        r0 = rx_pulses;
        start_cmd(4'd3, "b4");
        for (int i = 0; i < 4; i++) begin
            send_byte(WIDTH'(i + 1), WIDTH'(8'hC0 + i), 3, "b4");
            if (i < 3) begin
                check_val("b4_gap_tx_ready", 32'(tx_ready), 32'd0);
                check_val("b4_gap_enable", 32'(spi_enable), 32'd1);
            end
        end
        tick();
        tick();
        check_val("b4_busy_off", 32'(busy), 32'd0);
        tick();
        check_val("b4_en_cycles", 32'(en_cycles - e0), 32'd23);
        check_val("b4_rx_count", 32'(rx_pulses - r0), 32'd4);

        // TX underrun for 20 cycles mid-burst
        start_cmd(4'd1, "un");
        send_byte(8'h11, 8'h22, 2, "un1");
        tick();
        repeat (20) tick();
        check_val("un_enable", 32'(spi_enable), 32'd1);
        check_val("un_tx_ready", 32'(tx_ready), 32'd1);
        check_val("un_timeout", 32'(timeout), 32'd0);
        send_byte(8'h33, 8'h44, 2, "un2");
        tick();
        tick();
        check_val("un_busy_off", 32'(busy), 32'd0);
        check_val("un_timeout_end", 32'(timeout), 32'd0);

        // Timeout: byte never completes, expires after 64 SHIFT cycles
        r0 = rx_pulses;
        start_cmd(4'd2, "to");
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        wait_tx_ready("to");
        tick();
        tx_valid = 1'b0;
        n = 0;
        while (!timeout && n < 200) begin
            tick();
            n++;
        end
        check_val("to_cycles", 32'(n), 32'd64);
        check_val("to_hold_busy", 32'(busy), 32'd1);
        tick();
        tick();
        check_val("to_busy_off", 32'(busy), 32'd0);
        check_val("to_enable_off", 32'(spi_enable), 32'd0);
        check_val("to_sticky", 32'(timeout), 32'd1);
        check_val("to_rx_count", 32'(rx_pulses - r0), 32'd0);

        // Stray done in IDLE, command while busy, stray done in GAP
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        check_val("st_idle_busy", 32'(busy), 32'd0);
        check_val("st_idle_rx_valid", 32'(rx_valid), 32'd0);
        tick();
        r0 = rx_pulses;
        cmd_len   = 4'd1;
        cmd_valid = 1'b1;
        tick();
        check_val("st_timeout_clr", 32'(timeout), 32'd0);
        cmd_len = 4'd5;
        tick();
        check_val("st_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        tick();
        cmd_valid = 1'b0;
        check_val("st_busy", 32'(busy), 32'd1);
        send_byte(8'h66, 8'h77, 2, "st1");
        spi_rx_data = 8'hEE;
        spi_done    = 1'b1;
        tick();
        spi_done = 1'b0;
        check_val("st_gap_rx_valid", 32'(rx_valid), 32'd0);
        check_val("st_gap_rx_data", 32'(rx_data), 32'h77);
        check_val("st_gap_to_fetch", 32'(tx_ready), 32'd1);
        send_byte(8'h88, 8'h99, 1, "st2");
        tick();
        tick();
        check_val("st_busy_off", 32'(busy), 32'd0);
        tick();
        check_val("st_rx_count", 32'(rx_pulses - r0), 32'd2);

        // Asynchronous reset mid-SHIFT
        start_cmd(4'd0, "rs");
        tx_data  = 8'hAB;
        tx_valid = 1'b1;
        wait_tx_ready("rs");
        tick();
        tx_valid = 1'b0;
        repeat (3) tick();
        check_val("rs_busy_pre", 32'(busy), 32'd1);
        #2 reset_i = 1'b1;
        #1;
        check_val("rs_enable", 32'(spi_enable), 32'd0);
        check_val("rs_busy", 32'(busy), 32'd0);
        check_val("rs_rx_valid", 32'(rx_valid), 32'd0);
        check_val("rs_cmd_ready", 32'(cmd_ready), 32'd1);
        #2 reset_i = 1'b0;
        tick();
        check_val("rs_idle_after", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
